// File: rtl/div1_5.sv
// div1_5 -- fixed divide-by-1.5 clock generator.
// Uses both edges of clk_in: a rising-edge toggle flop and a falling-edge
// toggle flop, each paced by its own mod-3 counter, are XORed into clk_out.
// clk_out is high for one clk_in half-period out of every three.
// Optional build macro DIV1_5_RST_SYNC_EN: reset still asserts
// asynchronously, but its release is delayed through a 2-flop synchronizer
// on the clk_in rising edge (first output pulse two clk_in cycles later).
module div1_5 (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out
);

  logic       rst_core;
  logic [1:0] cnt_p;
  logic [1:0] cnt_n;
  logic       tog_p;
  logic       tog_n;
  logic       run;

  // Mod-3 successor; any illegal code falls back to 0.
  function automatic logic [1:0] next_cnt(input logic [1:0] c);
    case (c)
      2'd0:    next_cnt = 2'd1;
      2'd1:    next_cnt = 2'd2;
      default: next_cnt = 2'd0;
    endcase
  endfunction

`ifdef DIV1_5_RST_SYNC_EN
  logic [1:0] rst_sync;

  // Reset synchronizer: asserts at once, releases after two rising edges.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_core = rst_sync[1];
`else
  assign rst_core = rst;
`endif

  // Rising-edge side: toggles at P0, P2 of every 3-cycle group (count 0 and 2).
  // run marks that P0 has happened, so the falling side starts at N0.
  always_ff @(posedge clk_in or posedge rst_core) begin
    if (rst_core) begin
      cnt_p <= 2'd0;
      tog_p <= 1'b0;
      run   <= 1'b0;
    end else begin
      run   <= 1'b1;
      if (cnt_p == 2'd0 || cnt_p == 2'd2) tog_p <= ~tog_p;
      cnt_p <= next_cnt(cnt_p);
    end
  end

  // Falling-edge side: toggles at N0, N1 of every group (count 0 and 1),
  // idle until the first rising edge after reset release.
  always_ff @(negedge clk_in or posedge rst_core) begin
    if (rst_core) begin
      cnt_n <= 2'd0;
      tog_n <= 1'b0;
    end else if (run) begin
      if (cnt_n == 2'd0 || cnt_n == 2'd1) tog_n <= ~tog_n;
      cnt_n <= next_cnt(cnt_n);
    end
  end

  // Two flops never change on the same edge, so the XOR cannot glitch.
  // Edge sequence: rise P0, fall N0, rise N1, fall P2, repeat.
  assign clk_out = tog_p ^ tog_n;

endmodule

// File: tb/tb_div1_5.sv
// Directed bench for div1_5: sampled waveform table, rising-edge timing,
// reset behaviour (including truncation of a pulse in progress).
`timescale 1ns/1ps
module tb_div1_5;

  logic clk_in;
  logic rst;
  logic clk_out;

  int checks   = 0;
  int failures = 0;
  int bad_width = 0;
  int rises[$];

`ifdef DIV1_5_RST_SYNC_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int    t;
    logic  exp;
    string name;
  } vec_t;

  div1_5 dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .clk_out (clk_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_out) rises.push_back(int'($time));

  always @(negedge clk_out) begin
    if (!rst && rises.size() > 0) begin
      if (int'($time) - rises[$] != 5) bad_width++;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0d ns", name, act, exp, int'($time));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    if (int'($time) < t) #(t - int'($time));
  endtask

  function automatic int count_rises(input int lo, input int hi);
    int n = 0;
    foreach (rises[i]) if (rises[i] > lo && rises[i] <= hi) n++;
    return n;
  endfunction

  function automatic int nth_rise_after(input int lo, input int n);
    int k = 0;
    foreach (rises[i]) begin
      if (rises[i] > lo) begin
        if (k == n) return rises[i];
        k++;
      end
    end
    return -1;
  endfunction

  vec_t tbl[12];

  initial begin
    int prev;
    int bad_gap;

    // Default-build sample points (2 ns after each half-cycle boundary);
    // pulses at 105, 120, 135, 150 ns, each 5 ns wide.
    tbl[0]  = '{102, 1'b0, "pre_p0"};
    tbl[1]  = '{107, 1'b1, "pulse_p0"};
    tbl[2]  = '{112, 1'b0, "low_n0"};
    tbl[3]  = '{117, 1'b0, "low_p1"};
    tbl[4]  = '{122, 1'b1, "pulse_n1"};
    tbl[5]  = '{127, 1'b0, "low_p2"};
    tbl[6]  = '{132, 1'b0, "low_n2"};
    tbl[7]  = '{137, 1'b1, "pulse_p3"};
    tbl[8]  = '{142, 1'b0, "low_n3"};
    tbl[9]  = '{147, 1'b0, "low_p4"};
    tbl[10] = '{152, 1'b1, "pulse_n4"};
    tbl[11] = '{157, 1'b0, "low_p5"};

    rst = 1'b1;
    #3;
    check_bit("reset_state", clk_out, 1'b0);
    wait_until(97);
    check_bit("held_in_reset", clk_out, 1'b0);
    check_int("rises_during_reset", count_rises(0, 97), 0);
    wait_until(100);
    rst = 1'b0;

    foreach (tbl[i]) begin
      wait_until(tbl[i].t + LAT);
      check_bit(tbl[i].name, clk_out, tbl[i].exp);
    end

    wait_until(595);
    check_int("first_rise_time", nth_rise_after(100, 0), 105 + LAT);
    check_int("rise_count_100_590", count_rises(100, 590), (LAT == 0) ? 33 : 32);
    check_int("rises_in_30ns_window", count_rises(300, 330), 2);
    bad_gap = 0;
    prev = -1;
    foreach (rises[i]) begin
      if (rises[i] > 100 && rises[i] <= 590) begin
        if (prev >= 0 && rises[i] - prev != 15) bad_gap++;
        prev = rises[i];
      end
    end
    check_int("rise_spacing_errors", bad_gap, 0);

    // Restart from a fresh reset, then hit reset in the middle of a pulse.
    wait_until(700);
    rst = 1'b1;
    #2;
    check_bit("reassert_low", clk_out, 1'b0);
    wait_until(800);
    rst = 1'b0;
    wait_until(821);
    check_bit("pulse_before_trunc", clk_out, (LAT == 0) ? 1'b1 : 1'b0);
    wait_until(822);
    rst = 1'b1;
    #1;
    check_bit("truncated_pulse", clk_out, 1'b0);
    wait_until(850);
    check_bit("reset_held_850", clk_out, 1'b0);
    wait_until(897);
    check_bit("reset_held_897", clk_out, 1'b0);
    check_int("rises_while_reset", count_rises(822, 900), 0);
    rst = 1'b0;
    wait_until(900);
    rst = 1'b0;
    wait_until(907 + LAT);
    check_bit("restart_pulse_p0", clk_out, 1'b1);
    wait_until(912 + LAT);
    check_bit("restart_low_n0", clk_out, 1'b0);
    wait_until(960);
    check_int("restart_rise0", nth_rise_after(900, 0), 905 + LAT);
    check_int("restart_rise1", nth_rise_after(900, 1), 920 + LAT);
    check_int("high_width_errors", bad_width, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div1_5.md
DIV1_5 -- requirements
Module: div1_5

Interface
REQ-001 Parameters: none; the division ratio is fixed at 1.5 and has no parameter.
REQ-002 clk_in  input  1  source clock, 50% duty; both edges used.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 clk_out  output  1  divided clock, frequency = f(clk_in)/1.5.
REQ-005 The module SHALL have one clock, clk_in; reset rst SHALL be asynchronous and active-high.

Function
REQ-006 Output timing grid: half-cycles of clk_in, bounded alternately by rising and falling edges; clk_out period = 3 half-cycles of clk_in.
REQ-007 After reset release, first clk_in rising edge = P0; subsequent rising edges P1, P2, ...; falling edge following Pk = Nk.
REQ-008 clk_out SHALL rise at P0, P3, P6, ... and at N1, N4, N7, ... (alternating rising/falling source edge).
REQ-009 Each clk_out high phase SHALL last exactly one clk_in half-period; low phase exactly two half-periods (duty 1/3).
REQ-010 For every 3 clk_in cycles, clk_out SHALL emit exactly 2 pulses.
REQ-011 clk_out rising edges SHALL be spaced exactly 1.5 clk_in periods; no jitter beyond edge-skew of clk_in.
REQ-012 Internal state: one mod-3 counter on clk_in rising edge (0,1,2,0,...) and one on falling edge.
REQ-013 Each counter SHALL start at 0 at reset release.
REQ-014 clk_out SHALL be produced from registered signals combined by a single gate (AND/OR/XOR), glitch-free at every counter wrap.
REQ-015 Counters SHALL never reach value 3; any illegal state SHALL recover to 0 on the next active edge.
REQ-016 No combinational path from rst to clk_out other than forcing it low.

Reset
REQ-017 rst=1 SHALL force clk_out=0 and both counters=0 immediately, independent of clk_in.
REQ-018 Reset asserted mid-pulse SHALL truncate the pulse at once; no partial pulse after assertion.
REQ-019 After deassertion, the waveform SHALL restart from P0 per REQ-007/008 with no residual phase from before reset.
REQ-020 While rst=1, clk_out SHALL stay 0 regardless of clk_in activity.

Configuration
REQ-021 Macro DIV1_5_RST_SYNC_EN SHALL control reset deassertion.
- Defined: asynchronous assertion; deassertion passes through a 2-flop synchronizer clocked on clk_in rising edge.
- Defined: P0 = the 3rd clk_in rising edge after rst falls.
REQ-022 Macro undefined: reset acts directly; P0 = the 1st clk_in rising edge after rst falls.
REQ-023 Waveform shape, period and duty SHALL be identical in both builds; only the start latency differs.

Verification
REQ-024 Stimulus: clk_in period 10 ns (rising edges at 5, 15, ...); rst=1 for 0–100 ns; macro off.
- Required: clk_out rises at 105, 120, 135, ... ns.
- Required: each high phase 5 ns.
- Required: 33 rising edges in 100–590 ns.
REQ-025 Stimulus: rst=1 throughout, clk_in toggling -> clk_out constantly 0.
REQ-026 Stimulus: assert rst at 112 ns, release at 200 ns.
- Required: clk_out=0 from 112 ns.
- Required: next rising edges at 205, 220 ns.
REQ-027 Stimulus: macro on, same as REQ-024 -> first clk_out rise at 125 ns, then every 15 ns.
REQ-028 Stimulus: over any 30 ns window after start -> exactly 2 rising edges of clk_out and zero glitches narrower than 5 ns.
